proc_run_monitor: RTL and testbench
===================================

PROC_RUN_MONITOR -- requirements
Module: proc_run_monitor

Interface
REQ-001 Parameter DATA_W, default 32: width of monitored core output.
REQ-002 Parameter HOLD_CYCLES, default 50: cycles core reset is held after start.
REQ-003 Parameter STABLE_CYCLES, default 8: consecutive unchanged cycles that declare halt.
REQ-004 Parameter MAX_CYCLES, default 4096: RUN cycle budget before timeout.
REQ-005 Parameter DEPTH, default 16, power of two >= 2: trace FIFO entries.
REQ-006 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 Port rst  input  1  reset, asynchronous and active-low.
REQ-008 Port start  input  1  one-cycle pulse requesting a run.
REQ-009 Port r_out  input  DATA_W  monitored core output.
REQ-010 Port core_rst  output  1  active-high reset driven to the core.
REQ-011 Port trace_pop  input  1  read strobe for the trace FIFO.
REQ-012 Port trace_data  output  DATA_W  FIFO head entry, valid when trace_empty=0.
REQ-013 Port trace_empty / trace_full  output  1 each  FIFO status.
REQ-014 Port overflow  output  1  sticky: a trace push was dropped.
REQ-015 Port cycle_cnt  output  log2(MAX_CYCLES)+1  RUN cycles elapsed.
REQ-016 Port state  output  2  IDLE=0, HOLD=1, RUN=2, DONE=3.
REQ-017 Port halted / timeout  output  1 each  run termination cause.

Function
REQ-018 IDLE: core_rst=1; start moves to HOLD next cycle.
REQ-019 HOLD: core_rst=1 for exactly HOLD_CYCLES cycles, then RUN; start ignored.
REQ-020 Entry to HOLD clears cycle_cnt, halted, timeout, overflow, FIFO pointers and stable counter.
REQ-021 RUN: core_rst=0; cycle_cnt increments every RUN cycle, saturating at MAX_CYCLES.
REQ-022 RUN, first cycle: r_out pushed unconditionally, previous-value register loaded, stable counter=0.
REQ-023 RUN, later cycles: r_out != previous -> push r_out, update previous, stable counter=0; else stable counter+1.
REQ-024 Stable counter reaching STABLE_CYCLES -> halted=1, state DONE next cycle.
REQ-025 cycle_cnt reaching MAX_CYCLES without halt -> timeout=1, DONE next cycle; if both occur in the same cycle, halted=1 and timeout=0.
REQ-026 DONE: core_rst=1 (core frozen); flags and cycle_cnt held; FIFO remains readable; start returns to HOLD (per REQ-020).
REQ-027 FIFO: push when full drops the entry and sets overflow; pop when empty has no effect.
REQ-028 Simultaneous push and pop when full: both performed, count unchanged, no overflow.
REQ-029 Simultaneous push and pop when empty: push performed, pop ignored; trace_data valid next cycle.
REQ-030 Pointers wrap modulo DEPTH; full/empty from count register of width log2(DEPTH)+1.
REQ-031 trace_data is registered-free read of head entry (combinational from storage), zero-latency after pop.

Reset
REQ-032 rst=0 forces immediately: state=IDLE, core_rst=1, cycle_cnt=0, halted=0, timeout=0, overflow=0, trace_empty=1, trace_full=0, trace_data=0 contents don't-care.
REQ-033 rst asserted mid-run aborts the run; no trace entries are retained.
REQ-034 After rst deasserts, block stays in IDLE until start.

Verification (HOLD_CYCLES=4, STABLE_CYCLES=3, MAX_CYCLES=20, DEPTH=4, DATA_W=32)
REQ-035 start pulse -> core_rst=1 for 4 cycles in HOLD, falls with state=RUN on cycle 5.
REQ-036 r_out = 5,5,7,7,7,7 in RUN -> FIFO holds 5,7; halted=1, state=DONE; cycle_cnt=6.
REQ-037 r_out increments every cycle -> 4 pushes fill FIFO, 5th sets overflow; at cycle 20 timeout=1, halted=0.
REQ-038 FIFO full, trace_pop with concurrent push -> trace_full stays 1, overflow stays 0, head advances.
REQ-039 rst pulled low during RUN -> next observation state=0, core_rst=1, trace_empty=1, cycle_cnt=0.
REQ-040 start in DONE -> flags and FIFO cleared, new HOLD of 4 cycles, fresh trace.

Source files
------------

// File: rtl/proc_run_monitor.sv
// proc_run_monitor: sequences a core through reset hold and run phases.
// While the core runs, its output is watched for changes. Each change is
// logged into a small trace FIFO. The run ends when the output stays
// stable for long enough (halt) or when the cycle budget runs out
// (timeout).
//
// Handshake: trace_data is the FIFO head whenever trace_empty=0. A
// trace_pop sampled high on a rising clk edge with trace_empty=0 consumes
// that head. A pop while empty is ignored. There is no backpressure on
// pushes: a push into a full FIFO with no concurrent pop is dropped and
// sets the sticky overflow flag.
module proc_run_monitor #(
    parameter int DATA_W        = 32,
    parameter int HOLD_CYCLES   = 50,
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_CYCLES    = 4096,
    parameter int DEPTH         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_W-1:0]             r_out,
    output logic                          core_rst,
    input  logic                          trace_pop,
    output logic [DATA_W-1:0]             trace_data,
    output logic                          trace_empty,
    output logic                          trace_full,
    output logic                          overflow,
    output logic [$clog2(MAX_CYCLES):0]   cycle_cnt,
    output logic [1:0]                    state,
    output logic                          halted,
    output logic                          timeout
);

    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            st, st_next;
    logic [HW-1:0]     hold_cnt;
    logic [SW-1:0]     stable_cnt;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;

    logic enter_hold, first, changed, push, stable_hit, cnt_hit;
    logic do_pop, do_push, fifo_full;

    assign state       = st;
    assign fifo_full   = (count == (AW+1)'(DEPTH));
    assign trace_full  = fifo_full;
    assign trace_empty = (count == '0);
    // Head is read straight from storage; forced to zero when empty so the
    // output is defined after reset.
    assign trace_data  = trace_empty ? '0 : mem[rd_ptr];

    // Next-state decode and run-phase event detection.
    always_comb begin
        st_next    = st;
        core_rst   = 1'b1;
        enter_hold = 1'b0;
        first      = 1'b0;
        changed    = (r_out != prev);
        push       = 1'b0;
        stable_hit = 1'b0;
        cnt_hit    = 1'b0;
        case (st)
            IDLE: begin
                if (start) begin
                    st_next    = HOLD;
                    enter_hold = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) st_next = RUN;
            end
            RUN: begin
                core_rst   = 1'b0;
                first      = (cycle_cnt == '0);
                push       = first || changed;
                stable_hit = !push && (stable_cnt == SW'(STABLE_CYCLES - 1));
                cnt_hit    = (cycle_cnt == CW'(MAX_CYCLES - 1));
                if (stable_hit || cnt_hit) st_next = DONE;
            end
            DONE: begin
                if (start) begin
                    st_next    = HOLD;
                    enter_hold = 1'b1;
                end
            end
            default: st_next = IDLE;
        endcase
    end

    // A pop only counts when something is there; a push into a full FIFO
    // only proceeds when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop  = trace_pop && !trace_empty;
        do_push = push && (!fifo_full || do_pop);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else      st <= st_next;
    end

    // Hold timer, run counters, change tracking and termination flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt   <= '0;
            cycle_cnt  <= '0;
            stable_cnt <= '0;
            prev       <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
        end else if (enter_hold) begin
            hold_cnt   <= '0;
            cycle_cnt  <= '0;
            stable_cnt <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
        end else if (st == HOLD) begin
            hold_cnt <= hold_cnt + HW'(1);
        end else if (st == RUN) begin
            if (cycle_cnt != CW'(MAX_CYCLES)) cycle_cnt <= cycle_cnt + CW'(1);
            if (push) begin
                prev       <= r_out;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + SW'(1);
            end
            // A halt detected on the budget's last cycle takes precedence.
            if (stable_hit)            halted  <= 1'b1;
            if (cnt_hit && !stable_hit) timeout <= 1'b1;
        end
    end

    // Trace FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (enter_hold) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // Trace storage; contents need no reset since occupancy gates the read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= r_out;
    end

endmodule

// File: tb/tb_proc_run_monitor.sv
// Directed bench for proc_run_monitor with small parameters so every
// phase (hold, halt, timeout, FIFO corner cases, reset abort) is reachable
// in a short run.
module tb_proc_run_monitor;

    localparam int DATA_W = 32;
    localparam int HOLD   = 4;
    localparam int STABLE = 3;
    localparam int MAXC   = 20;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(MAXC) + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] r_out;
    logic              core_rst;
    logic              trace_pop;
    logic [DATA_W-1:0] trace_data;
    logic              trace_empty;
    logic              trace_full;
    logic              overflow;
    logic [CW-1:0]     cycle_cnt;
    logic [1:0]        state;
    logic              halted;
    logic              timeout;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];

    proc_run_monitor #(
        .DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .STABLE_CYCLES(STABLE),
        .MAX_CYCLES(MAXC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .r_out(r_out),
        .core_rst(core_rst), .trace_pop(trace_pop), .trace_data(trace_data),
        .trace_empty(trace_empty), .trace_full(trace_full), .overflow(overflow),
        .cycle_cnt(cycle_cnt), .state(state), .halted(halted), .timeout(timeout)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and verify the HOLD window: four HOLD cycles, then RUN.
    task automatic do_start(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_clr_halted"},  32'(halted), 32'd0);
        chk({tag, "_clr_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_clr_ovf"},     32'(overflow), 32'd0);
        chk({tag, "_clr_empty"},   32'(trace_empty), 32'd1);
        chk({tag, "_clr_cnt"},     32'(cycle_cnt), 32'd0);
        for (int i = 0; i < HOLD; i++) begin
            chk({tag, "_hold_state"}, 32'(state), 32'd1);
            chk({tag, "_hold_crst"},  32'(core_rst), 32'd1);
            if (i < HOLD - 1) step();
        end
        step();
        chk({tag, "_run_state"}, 32'(state), 32'd2);
        chk({tag, "_run_crst"},  32'(core_rst), 32'd0);
    endtask

    // Pop everything and compare against the expected trace queue.
    task automatic drain(input string tag);
        logic [DATA_W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_empty"}, 32'(trace_empty), 32'd0);
            chk({tag, "_data"},  trace_data, e);
            trace_pop = 1'b1;
            step();
            trace_pop = 1'b0;
        end
        chk({tag, "_end_empty"}, 32'(trace_empty), 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; r_out = '0; trace_pop = 1'b0;
        #2;
        // reset state
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_crst", 32'(core_rst), 32'd1);
        chk("rst_cnt", 32'(cycle_cnt), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_empty", 32'(trace_empty), 32'd1);
        chk("rst_full", 32'(trace_full), 32'd0);
        chk("rst_data", trace_data, 32'd0);
        step();
        rst = 1'b1;
        step(); step();
        chk("idle_stay", 32'(state), 32'd0);
        // pop when empty has no effect
        trace_pop = 1'b1;
        step();
        trace_pop = 1'b0;
        chk("pop_empty", 32'(trace_empty), 32'd1);
        chk("pop_empty_full", 32'(trace_full), 32'd0);

        // Run 1: halt on stable output
        do_start("r1");
        begin
            logic [DATA_W-1:0] seq [6];
            seq = '{32'd5, 32'd5, 32'd7, 32'd7, 32'd7, 32'd7};
            for (int i = 0; i < 6; i++) begin
                r_out = seq[i];
                step();
                chk("r1_cnt", 32'(cycle_cnt), 32'(i + 1));
                if (i < 5) chk("r1_running", 32'(state), 32'd2);
            end
        end
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd7);
        chk("r1_state_done", 32'(state), 32'd3);
        chk("r1_halted", 32'(halted), 32'd1);
        chk("r1_timeout", 32'(timeout), 32'd0);
        chk("r1_crst", 32'(core_rst), 32'd1);
        r_out = 32'd99;
        step();
        chk("r1_cnt_held", 32'(cycle_cnt), 32'd6);
        drain("r1_trace");

        // Run 2: incrementing output, overflow and timeout
        do_start("r2");
        for (int k = 1; k <= MAXC; k++) begin
            r_out = 32'(100 + k);
            step();
            chk("r2_cnt", 32'(cycle_cnt), 32'(k));
            if (k == 4) begin
                chk("r2_full4", 32'(trace_full), 32'd1);
                chk("r2_ovf4", 32'(overflow), 32'd0);
            end
            if (k == 5) chk("r2_ovf5", 32'(overflow), 32'd1);
            if (k == MAXC - 1) begin
                chk("r2_state19", 32'(state), 32'd2);
                chk("r2_to19", 32'(timeout), 32'd0);
            end
        end
        chk("r2_state_done", 32'(state), 32'd3);
        chk("r2_timeout", 32'(timeout), 32'd1);
        chk("r2_halted", 32'(halted), 32'd0);
        step(); step();
        chk("r2_cnt_held", 32'(cycle_cnt), 32'(MAXC));
        chk("r2_state_held", 32'(state), 32'd3);
        for (int k = 1; k <= DEPTH; k++) exp_q.push_back(32'(100 + k));
        drain("r2_trace");

        // Run 3: push+pop on empty, push+pop on full, reset abort
        do_start("r3");
        r_out = 32'd1;
        trace_pop = 1'b1;
        step();
        trace_pop = 1'b0;
        chk("r3_pp_empty", 32'(trace_empty), 32'd0);
        chk("r3_pp_data", trace_data, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            r_out = 32'(k);
            step();
        end
        chk("r3_full", 32'(trace_full), 32'd1);
        chk("r3_head1", trace_data, 32'd1);
        r_out = 32'd5;
        trace_pop = 1'b1;
        step();
        trace_pop = 1'b0;
        chk("r3_pp_full", 32'(trace_full), 32'd1);
        chk("r3_pp_ovf", 32'(overflow), 32'd0);
        chk("r3_pp_head", trace_data, 32'd2);
        chk("r3_state", 32'(state), 32'd2);
        // asynchronous abort mid-run
        #2;
        rst = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_crst", 32'(core_rst), 32'd1);
        chk("abort_empty", 32'(trace_empty), 32'd1);
        chk("abort_cnt", 32'(cycle_cnt), 32'd0);
        step();
        rst = 1'b1;
        r_out = 32'd0;
        step(); step();
        chk("abort_idle", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so a wedged run still ends with a report.
    initial begin
        #20000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
